instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_buffer.sv | 58 +++++
 rtl/instr_fetch.sv | 102 ++++++++++
 tb/tb_instr_fetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset address and state encoding for the fetch unit
package fetch_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL,
        ST_REDIRECT
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - prefetch FIFO of {pc, word} pairs with single push/pop and flush
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [CW-1:0]     count,
    output logic [ADDR_W-1:0] head_pc,
    output logic [WORD_W-1:0] head_data
);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [WORD_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= push_pc;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is never cleared, so the head is forced to zero whenever nothing is held.
    assign head_pc   = (count != '0) ? pc_mem[rd_ptr]   : '0;
    assign head_data = (count != '0) ? data_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && count == CW'(DEPTH)));
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction prefetch unit: issues word reads, buffers returns, handles redirects
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetchEn,
    output logic              memread,
    output logic [ADDR_W-1:0] adr,
    input  logic [WORD_W-1:0] memdata,
    output logic [WORD_W-1:0] instruction,
    output logic              instrValid,
    input  logic              instrReady,
    output logic [ADDR_W-1:0] fetchPc,
    input  logic              branchEn,
    input  logic [ADDR_W-1:0] branchTarget
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic [CW-1:0]     count;
    logic [3:0]        occ_now;
    logic [3:0]        occ_next;

    // A redirect discards the returning word and the head pop in the same cycle.
    assign pop  = instrValid & instrReady & ~branchEn;
    assign push = inflight & ~branchEn;

    // Slots already committed: buffered words plus the word returning now, less what leaves now.
    assign occ_now  = 4'(count) + 4'(inflight) - 4'(pop);
    assign issue    = ~rst & ~branchEn & fetchEn & (state != ST_IDLE) & (occ_now < 4'(DEPTH));
    assign occ_next = occ_now + 4'(issue);

    assign memread    = issue;
    assign adr        = pc;
    assign instrValid = (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (branchEn) begin
                pc <= branchTarget;
            end else if (issue) begin
                pc <= pc + ADDR_W'(1);
            end
            if (branchEn) begin
                state <= ST_REDIRECT;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fetchEn) begin
                            state <= ST_FETCH;
                        end
                    end
                    default: begin
                        if (!fetchEn) begin
                            state <= ST_IDLE;
                        end else if (occ_next >= 4'(DEPTH)) begin
                            state <= ST_FULL;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                endcase
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (branchEn),
        .push      (push),
        .push_pc   (inflight_pc),
        .push_data (memdata),
        .pop       (pop),
        .count     (count),
        .head_pc   (fetchPc),
        .head_data (instruction)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch against a word memory of 16'hA000+address
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk;
    logic        rst;
    logic        fetchEn;
    logic        memread;
    logic [15:0] adr;
    logic [15:0] memdata;
    logic [15:0] instruction;
    logic        instrValid;
    logic        instrReady;
    logic [15:0] fetchPc;
    logic        branchEn;
    logic [15:0] branchTarget;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_adr[$];
    logic [15:0] exp_pc[$];

    instr_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fetchEn      (fetchEn),
        .memread      (memread),
        .adr          (adr),
        .memdata      (memdata),
        .instruction  (instruction),
        .instrValid   (instrValid),
        .instrReady   (instrReady),
        .fetchPc      (fetchPc),
        .branchEn     (branchEn),
        .branchTarget (branchTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial memdata = 16'h0BAD;
    always @(posedge clk) begin
        memdata <= memread ? 16'(16'hA000 + adr) : 16'h0BAD;
    end

    task automatic push_adr(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_adr.push_back(16'(start + i));
    endtask

    task automatic push_pc(input logic [15:0] start, input int n);
        for (int i = 0; i < n; i++) exp_pc.push_back(16'(start + i));
    endtask

    task automatic score();
        logic [15:0] e;
        #1;
        if (memread === 1'b1) begin
            tests++;
            if (exp_adr.size() == 0) begin
                fails++;
                $display("FAIL read_unexpected adr=%h required=no read", adr);
            end else begin
                e = exp_adr.pop_front();
                if (adr !== e) begin
                    fails++;
                    $display("FAIL read_adr adr=%h required=%h", adr, e);
                end
            end
        end
        if (instrValid === 1'b1 && instrReady && !branchEn && !rst) begin
            tests++;
            if (exp_pc.size() == 0) begin
                fails++;
                $display("FAIL deliver_unexpected fetchPc=%h required=no word", fetchPc);
            end else begin
                e = exp_pc.pop_front();
                if (fetchPc !== e) begin
                    fails++;
                    $display("FAIL deliver_pc fetchPc=%h required=%h", fetchPc, e);
                end
                tests++;
                if (instruction !== 16'(16'hA000 + e)) begin
                    fails++;
                    $display("FAIL deliver_word instruction=%h required=%h", instruction, 16'(16'hA000 + e));
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; fetchEn = 1'b0; instrReady = 1'b0; branchEn = 1'b0; branchTarget = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_adr.delete();
        exp_pc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; fetchEn = 1'b1; instrReady = 1'b1; branchEn = 1'b1; branchTarget = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (memread !== 1'b0) begin fails++; $display("FAIL reset_memread actual=%b required=0", memread); end
        tests++; if (adr !== RESET_PC) begin fails++; $display("FAIL reset_adr actual=%h required=%h", adr, RESET_PC); end
        tests++; if (instruction !== 16'h0000) begin fails++; $display("FAIL reset_instruction actual=%h required=0000", instruction); end
        tests++; if (instrValid !== 1'b0) begin fails++; $display("FAIL reset_instrValid actual=%b required=0", instrValid); end
        tests++; if (fetchPc !== 16'h0000) begin fails++; $display("FAIL reset_fetchPc actual=%h required=0000", fetchPc); end
        rst = 1'b0; branchEn = 1'b0; fetchEn = 1'b0; instrReady = 1'b0;
        exp_adr.delete();
        exp_pc.delete();
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            score();
            tests++;
            if (memread !== 1'b0) begin fails++; $display("FAIL idle_no_read actual=%b required=0", memread); end
            @(negedge clk);
        end
    endtask

    task automatic test_stream();
        do_reset();
        push_adr(16'h0000, 11);
        push_pc(16'h0000, 9);
        fetchEn = 1'b1; instrReady = 1'b1;
        for (int j = 0; j < 12; j++) begin
            score();
            if (j >= 1) begin
                tests++;
                if (memread !== 1'b1) begin fails++; $display("FAIL stream_read cycle=%0d actual=%b required=1", j, memread); end
            end
            if (j == 2) begin
                tests++;
                if (instrValid !== 1'b0) begin fails++; $display("FAIL stream_latency_early actual=%b required=0", instrValid); end
            end
            if (j == 3) begin
                tests++;
                if (instrValid !== 1'b1) begin fails++; $display("FAIL stream_latency actual=%b required=1", instrValid); end
            end
            @(negedge clk);
        end
        tests++;
        if (exp_adr.size() != 0 || exp_pc.size() != 0) begin
            fails++; $display("FAIL stream_left reads=%0d words=%0d required=0 0", exp_adr.size(), exp_pc.size());
        end
    endtask

    task automatic test_stall();
        do_reset();
        push_adr(16'h0000, DEPTH);
        fetchEn = 1'b1; instrReady = 1'b0;
        for (int j = 0; j < 8; j++) begin
            score();
            if (j == 7) begin
                tests++;
                if (instrValid !== 1'b1 || fetchPc !== 16'h0000) begin
                    fails++; $display("FAIL stall_head valid=%b fetchPc=%h required=1 0000", instrValid, fetchPc);
                end
            end
            @(negedge clk);
        end
        tests++;
        if (exp_adr.size() != 0) begin fails++; $display("FAIL stall_reads left=%0d required=0", exp_adr.size()); end
        push_adr(16'h0002, 6);
        push_pc(16'h0000, 6);
        instrReady = 1'b1;
        for (int r = 0; r < 6; r++) begin
            score();
            @(negedge clk);
        end
        tests++;
        if (exp_adr.size() != 0 || exp_pc.size() != 0) begin
            fails++; $display("FAIL stall_left reads=%0d words=%0d required=0 0", exp_adr.size(), exp_pc.size());
        end
    endtask

    task automatic test_branch();
        do_reset();
        push_adr(16'h0000, 6);
        push_pc(16'h0000, 4);
        push_adr(16'h0040, 6);
        push_pc(16'h0040, 4);
        fetchEn = 1'b1; instrReady = 1'b1;
        for (int j = 0; j < 14; j++) begin
            branchEn     = (j == 7);
            branchTarget = (j == 7) ? 16'h0040 : 16'h0BAD;
            score();
            if (j == 7) begin
                tests++;
                if (memread !== 1'b0) begin fails++; $display("FAIL branch_suppress memread=%b required=0", memread); end
            end
            if (j == 8) begin
                tests++;
                if (instrValid !== 1'b0) begin fails++; $display("FAIL branch_flush instrValid=%b required=0", instrValid); end
            end
            @(negedge clk);
        end
        branchEn = 1'b0;
        tests++;
        if (exp_adr.size() != 0 || exp_pc.size() != 0) begin
            fails++; $display("FAIL branch_left reads=%0d words=%0d required=0 0", exp_adr.size(), exp_pc.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        push_adr(16'hFFFE, 6);
        push_pc(16'hFFFE, 4);
        fetchEn = 1'b1; instrReady = 1'b1;
        for (int j = 0; j < 8; j++) begin
            branchEn     = (j < 2);
            branchTarget = (j == 0) ? 16'h1234 : 16'hFFFE;
            score();
            if (j == 1) begin
                tests++;
                if (memread !== 1'b0) begin fails++; $display("FAIL redirect_hold memread=%b required=0", memread); end
            end
            if (j == 2) begin
                tests++;
                if (memread !== 1'b1) begin fails++; $display("FAIL redirect_first_read memread=%b required=1", memread); end
            end
            @(negedge clk);
        end
        tests++;
        if (exp_adr.size() != 0 || exp_pc.size() != 0) begin
            fails++; $display("FAIL wrap_left reads=%0d words=%0d required=0 0", exp_adr.size(), exp_pc.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_adr(16'h0000, 2);
        fetchEn = 1'b1; instrReady = 1'b0;
        for (int j = 0; j < 3; j++) begin
            score();
            @(negedge clk);
        end
        rst = 1'b1; branchEn = 1'b1; branchTarget = 16'h0077; instrReady = 1'b1;
        score();
        @(negedge clk);
        score();
        tests++; if (memread !== 1'b0) begin fails++; $display("FAIL midrst_memread actual=%b required=0", memread); end
        tests++; if (adr !== RESET_PC) begin fails++; $display("FAIL midrst_adr actual=%h required=%h", adr, RESET_PC); end
        tests++; if (instruction !== 16'h0000) begin fails++; $display("FAIL midrst_instruction actual=%h required=0000", instruction); end
        tests++; if (instrValid !== 1'b0) begin fails++; $display("FAIL midrst_instrValid actual=%b required=0", instrValid); end
        tests++; if (fetchPc !== 16'h0000) begin fails++; $display("FAIL midrst_fetchPc actual=%h required=0000", fetchPc); end
        rst = 1'b0; branchEn = 1'b0;
        push_adr(RESET_PC, 6);
        push_pc(RESET_PC, 4);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            score();
            @(negedge clk);
        end
        tests++;
        if (exp_adr.size() != 0 || exp_pc.size() != 0) begin
            fails++; $display("FAIL midrst_left reads=%0d words=%0d required=0 0", exp_adr.size(), exp_pc.size());
        end
    endtask

    task automatic test_fetch_stop();
        do_reset();
        push_adr(16'h0000, 1);
        push_pc(16'h0000, 1);
        instrReady = 1'b1;
        for (int j = 0; j < 9; j++) begin
            fetchEn = (j < 2);
            score();
            if (j >= 2) begin
                tests++;
                if (memread !== 1'b0) begin fails++; $display("FAIL stop_no_read cycle=%0d memread=%b required=0", j, memread); end
            end
            if (j == 3) begin
                tests++;
                if (instrValid !== 1'b1) begin fails++; $display("FAIL stop_deliver instrValid=%b required=1", instrValid); end
            end
            @(negedge clk);
        end
        push_adr(16'h0001, 1);
        fetchEn = 1'b1;
        score();
        tests++;
        if (memread !== 1'b0) begin fails++; $display("FAIL restart_idle memread=%b required=0", memread); end
        @(negedge clk);
        score();
        @(negedge clk);
        tests++;
        if (exp_adr.size() != 0 || exp_pc.size() != 0) begin
            fails++; $display("FAIL stop_left reads=%0d words=%0d required=0 0", exp_adr.size(), exp_pc.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_wrap();
        test_reset_mid();
        test_fetch_stop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=finish earlier", $time);
        $fatal(1);
    end

endmodule
